// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-input, W-bit streaming mux with valid/ready handshakes,
// packet locking and a registered output stage.
//   Clk, Rst_n          clock, asynchronous active-low reset
//   Mode, Sel           0 = explicit channel select via Sel, 1 = round-robin
//   In_valid/last/data  per-channel source stream (channel i at [i*WIDTH +: WIDTH])
//   In_ready            per-channel ready, one-hot or zero
//   Out_valid/data/last/src  registered output beat and its source index
//   Out_ready           downstream ready

// Per-channel slice: ready decode plus a masked copy of the beat so the top
// can OR-reduce the winning channel without indexing by grant.
module stream_mux_arb_lane #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic             en,
  input  logic [SEL_W-1:0] grant,
  input  logic             valid,
  input  logic             last,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             take,
  output logic [WIDTH-1:0] data_m,
  output logic             last_m
);
  assign ready  = en & (grant == SEL_W'(IDX));
  assign take   = ready & valid;
  assign data_m = take ? data : '0;
  assign last_m = take & last;
endmodule

module stream_mux_arb #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    Mode,
  input  logic [SEL_W-1:0]        Sel,
  input  logic [NUM_IN-1:0]       In_valid,
  input  logic [NUM_IN-1:0]       In_last,
  input  logic [NUM_IN*WIDTH-1:0] In_data,
  output logic [NUM_IN-1:0]       In_ready,
  output logic                    Out_valid,
  output logic [WIDTH-1:0]        Out_data,
  output logic                    Out_last,
  output logic [SEL_W-1:0]        Out_src,
  input  logic                    Out_ready
);
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                        state, state_nxt;
  logic [SEL_W-1:0]              lock_ch, lock_nxt;
  logic [SEL_W-1:0]              rr_ptr, rr_nxt;
  logic [SEL_W-1:0]              grant;
  logic                          grant_ok;
  logic                          ld, en, xfer, last_x;
  logic [NUM_IN-1:0]             take, last_m;
  logic [NUM_IN-1:0][WIDTH-1:0]  data_m;
  logic [WIDTH-1:0]              data_x;

  assign ld = ~Out_valid | Out_ready;
  // Rst_n gates ready so nothing is offered while reset is held.
  assign en = ld & grant_ok & Rst_n;

  // Grant selection. Round-robin scans upward from rr_ptr+1 with wrap.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    grant_ok = 1'b0;
    if (state == LOCKED) begin
      grant    = lock_ch;
      grant_ok = 1'b1;
    end else if (!Mode) begin
      grant    = Sel;
      grant_ok = int'(Sel) < NUM_IN;
    end else begin
      for (int k = 1; k <= NUM_IN; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_IN;
        if (!grant_ok && In_valid[idx]) begin
          grant    = SEL_W'(idx);
          grant_ok = 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    stream_mux_arb_lane #(.WIDTH(WIDTH), .SEL_W(SEL_W), .IDX(i)) u_lane (
      .en     (en),
      .grant  (grant),
      .valid  (In_valid[i]),
      .last   (In_last[i]),
      .data   (In_data[i*WIDTH +: WIDTH]),
      .ready  (In_ready[i]),
      .take   (take[i]),
      .data_m (data_m[i]),
      .last_m (last_m[i])
    );
  end

  // At most one lane takes, so an OR-reduction is the mux.
  always_comb begin
    data_x = '0;
    for (int i = 0; i < NUM_IN; i++) data_x = data_x | data_m[i];
  end
  assign xfer   = |take;
  assign last_x = |last_m;

  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_ch;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: if (xfer) begin
        if (!last_x) begin
          state_nxt = LOCKED;
          lock_nxt  = grant;
        end else if (Mode) begin
          rr_nxt = grant;
        end
      end
      LOCKED: if (xfer && last_x) begin
        state_nxt = IDLE;
        if (Mode) rr_nxt = lock_ch;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      lock_ch <= '0;
      rr_ptr  <= SEL_W'(NUM_IN - 1);
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_nxt;
      rr_ptr  <= rr_nxt;
    end
  end

  // Output register; payload fields keep stale values when the beat drains.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Out_valid <= 1'b0;
      Out_data  <= '0;
      Out_last  <= 1'b0;
      Out_src   <= '0;
    end else if (xfer) begin
      Out_valid <= 1'b1;
      Out_data  <= data_x;
      Out_last  <= last_x;
      Out_src   <= grant;
    end else if (Out_ready) begin
      Out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/stream_mux_arb.md
# stream_mux_arb

Parametrised N-input, W-bit streaming multiplexer with valid/ready handshakes, packet locking and a registered output stage. It succeeds the fixed-width combinational mux family for datapaths where sources are decoupled producers rather than static buses, such as writeback, memory-response and debug-trace merging. Source selection is either explicit (`Sel`) or round-robin arbitration. A granted source keeps the output until its last beat.

## Interface
Parameters:
- `WIDTH`, default 32: data width per channel, ≥1.
- `NUM_IN`, default 4: number of input channels, 2..64.
- `SEL_W`, default $clog2(NUM_IN): width of the select and source-ID fields.

Ports:
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `Mode`  in  1  0 = explicit select via `Sel`; 1 = round-robin arbitration.
- `Sel`  in  SEL_W  channel index used when `Mode`=0.
- `In_valid`  in  NUM_IN  per-channel valid.
- `In_last`  in  NUM_IN  per-channel end-of-packet flag, qualified by `In_valid`.
- `In_data`  in  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `In_ready`  out  NUM_IN  per-channel ready; at most one bit high at a time.
- `Out_valid`  out  1  output register holds a beat.
- `Out_data`  out  WIDTH  registered data.
- `Out_last`  out  1  registered last flag.
- `Out_src`  out  SEL_W  index of the channel that produced the beat.
- `Out_ready`  in  1  downstream ready.

## Operation
- Handshakes:
  - A beat transfers on channel i when `In_valid[i]` and `In_ready[i]` are both high at the clock edge.
  - A beat leaves the block when `Out_valid` and `Out_ready` are both high.
- Output register load enable: `ld = ~Out_valid | Out_ready`.
- `In_ready[i] = ld & (grant == i) & grant_ok`. This is combinational from state, `Mode`, `Sel`, `In_valid` and `Out_ready`.
- Arbiter FSM has two states:
  - IDLE: grant is combinational.
    - Mode 0: grant = `Sel`. `grant_ok` = (`Sel` < NUM_IN). An out-of-range `Sel` produces no grant.
    - Mode 1: grant = first channel with `In_valid` set, searching upward from `rr_ptr`+1 with modulo-NUM_IN wrap. `grant_ok` = any `In_valid`.
    - Transfer with `In_last`=0: register the grant into `lock_ch` and go to LOCKED.
    - Transfer with `In_last`=1: stay in IDLE. In Mode 1, set `rr_ptr` to the grant.
  - LOCKED: grant = `lock_ch`, `grant_ok`=1. `Mode` and `Sel` are ignored.
    - Transfer with `In_last`=1: go to IDLE. In Mode 1, set `rr_ptr` to `lock_ch`.
    - Other channels stay stalled however long the locked channel withholds valid.
- Mode 0 does not update `rr_ptr`.
- A `Mode` or `Sel` change while LOCKED takes effect only after return to IDLE.
- On a transfer:
  - `Out_data`, `Out_last` and `Out_src` take the granted channel's data, its last flag, and the grant index.
  - `Out_valid` is set.
- With `Out_ready`=1 and no input transfer, `Out_valid` clears. `Out_data`, `Out_last` and `Out_src` hold their stale values.
- Data is never dropped or duplicated. Beats from one channel leave in order, and packets are never interleaved on the output.

## Timing
- Latency: an input beat accepted at edge k is presented on the outputs from edge k, i.e. visible in cycle k+1.
- Throughput: one beat per cycle with `Out_ready` held high, including back-to-back packets from different channels.
- No bubble is inserted on a grant switch.
- Backpressure: with `Out_ready`=0 and `Out_valid`=1, all `In_ready` are 0 in the same cycle (combinational path `Out_ready` → `In_ready`).
- Reset values while `Rst_n`=0, applied immediately and asynchronously:
  - `Out_valid`=0, `Out_data`=0, `Out_last`=0, `Out_src`=0.
  - State = IDLE, `lock_ch`=0.
  - `rr_ptr`=NUM_IN-1, so channel 0 has first round-robin priority.
  - `In_ready` forced to all 0.
- Reset mid-packet: lock and output beat are discarded. After release, arbitration restarts from the reset state.
- Reset deassertion is synchronised externally; the block has no internal reset synchroniser.

## Test plan
- Reset then explicit select (Mode 0, NUM_IN=4, WIDTH=32):
  - Stimulus: `Sel`=2; channel 2 sends single-beat 0xA5A5_0002 with last=1; `Out_ready`=1.
  - Required: `Out_valid`=1 next cycle, `Out_data`=0xA5A5_0002, `Out_src`=2, `Out_last`=1. `In_ready`=4'b0000 during reset.
- Packet lock:
  - Stimulus: Mode 0, `Sel`=1, channel 1 sends a 3-beat packet; `Sel` switches to 3 after beat 1.
  - Required: all 3 beats emerge with `Out_src`=1. Channel 3 gets `In_ready` only in the cycle after beat 3 is accepted.
- Round-robin fairness:
  - Stimulus: Mode 1, all four channels continuously valid with single-beat packets.
  - Required: `Out_src` sequence 0,1,2,3,0,1… at one beat per cycle, with no bubbles.
- Backpressure:
  - Stimulus: Mode 1, `Out_ready` toggles 1,0,0,1; channel 0 streams 0x10,0x11,0x12.
  - Required: `Out_data` holds while `Out_ready`=0; each value appears exactly once in order; `In_ready`=0 while stalled.
- Out-of-range select:
  - Stimulus: NUM_IN=3, Mode 0, `Sel`=3, all valid.
  - Required: `In_ready`=0 and `Out_valid` stays 0.
- Reset mid-packet:
  - Stimulus: assert `Rst_n`=0 after beat 1 of a 4-beat packet on channel 2 (Mode 1); release; channel 1 valid.
  - Required: `Out_valid` drops immediately; first post-reset grant goes to channel 1, since `rr_ptr` is back at 3.
